// File: rtl/l1_axi_arb_if.sv
// AXI port bundle (AR/R/AW/W/B) shared by the L1 masters and the interconnect port of l1_axi_arb.
// master = side that issues addresses; slave = side that returns data and responses.
interface l1_axi_arb_if #(
    parameter int AW  = 32,
    parameter int DW  = 32,
    parameter int IDW = 10
);
    logic [AW-1:0]   araddr;
    logic [1:0]      arburst;
    logic [2:0]      arsize;
    logic [IDW-1:0]  arid;
    logic [7:0]      arlen;
    logic            arvalid;
    logic            arready;

    logic [DW-1:0]   rdata;
    logic [1:0]      rresp;
    logic [IDW-1:0]  rid;
    logic            rlast;
    logic            rvalid;
    logic            rready;

    logic [AW-1:0]   awaddr;
    logic [1:0]      awburst;
    logic [2:0]      awsize;
    logic [IDW-1:0]  awid;
    logic [7:0]      awlen;
    logic            awvalid;
    logic            awready;

    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
    logic [IDW-1:0]  wid;
    logic            wlast;
    logic            wvalid;
    logic            wready;

    logic [IDW-1:0]  bid;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;

    modport master (
        output araddr, arburst, arsize, arid, arlen, arvalid,
        input  arready,
        input  rdata, rresp, rid, rlast, rvalid,
        output rready,
        output awaddr, awburst, awsize, awid, awlen, awvalid,
        input  awready,
        output wdata, wstrb, wid, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  araddr, arburst, arsize, arid, arlen, arvalid,
        output arready,
        output rdata, rresp, rid, rlast, rvalid,
        input  rready,
        input  awaddr, awburst, awsize, awid, awlen, awvalid,
        output awready,
        input  wdata, wstrb, wid, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/l1_axi_arb.sv
// Two-to-one AXI arbiter between the L1 I-cache (s0) / D-cache (s1) and the interconnect (m).
// Default: fixed priority s1 > s0. Define L1_ARB_RR_EN for per-channel round-robin on ties.
//
//  state  | meaning
//  R_IDLE | no read owner; arbitrate pending arvalid
//  R_ADDR | AR of s[rgnt] passes through to m
//  R_DATA | R beats route back to s[rgnt] until rlast
//  W_IDLE | no write owner; arbitrate pending awvalid
//  W_XFER | AW and W of s[wgnt] pass through, each exactly once
//  W_RESP | B routes back to s[wgnt]
module l1_axi_arb (
    input logic          clk,
    input logic          rst,
    l1_axi_arb_if.slave  s0,
    l1_axi_arb_if.slave  s1,
    l1_axi_arb_if.master m
);
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_XFER, W_RESP} w_state_t;

    r_state_t   r_state, r_state_nxt;
    w_state_t   w_state, w_state_nxt;
    logic       rgnt, rgnt_nxt;
    logic       wgnt, wgnt_nxt;
    logic       aw_done, aw_done_nxt;
    logic       w_done, w_done_nxt;
    logic       r_win, w_win;
    logic       r_done, b_done;

    logic       m_arvalid_c, m_rready_c;
    logic       m_awvalid_c, m_wvalid_c, m_bready_c;
    logic [1:0] s_arready, s_rvalid;
    logic [1:0] s_awready, s_wready, s_bvalid;

    // Without a tie the sole requester wins, which is s1 whenever s1 is requesting.
`ifdef L1_ARB_RR_EN
    logic r_ptr, w_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= 1'b0;
            w_ptr <= 1'b0;
        end else begin
            if (r_done) r_ptr <= rgnt;
            if (b_done) w_ptr <= wgnt;
        end
    end

    assign r_win = (s0.arvalid && s1.arvalid) ? ~r_ptr : s1.arvalid;
    assign w_win = (s0.awvalid && s1.awvalid) ? ~w_ptr : s1.awvalid;
`else
    assign r_win = s1.arvalid;
    assign w_win = s1.awvalid;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= R_IDLE;
            w_state <= W_IDLE;
            rgnt    <= 1'b0;
            wgnt    <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            r_state <= r_state_nxt;
            w_state <= w_state_nxt;
            rgnt    <= rgnt_nxt;
            wgnt    <= wgnt_nxt;
            aw_done <= aw_done_nxt;
            w_done  <= w_done_nxt;
        end
    end

    always_comb begin
        r_state_nxt = r_state;
        rgnt_nxt    = rgnt;
        m_arvalid_c = 1'b0;
        m_rready_c  = 1'b0;
        s_arready   = 2'b00;
        s_rvalid    = 2'b00;
        r_done      = 1'b0;
        case (r_state)
            R_IDLE: begin
                if (s0.arvalid || s1.arvalid) begin
                    rgnt_nxt    = r_win;
                    r_state_nxt = R_ADDR;
                end
            end
            R_ADDR: begin
                m_arvalid_c     = rgnt ? s1.arvalid : s0.arvalid;
                s_arready[rgnt] = m.arready;
                if (m_arvalid_c && m.arready) r_state_nxt = R_DATA;
            end
            R_DATA: begin
                m_rready_c     = rgnt ? s1.rready : s0.rready;
                s_rvalid[rgnt] = m.rvalid;
                if (m.rvalid && m_rready_c && m.rlast) begin
                    r_done      = 1'b1;
                    r_state_nxt = R_IDLE;
                end
            end
            default: r_state_nxt = R_IDLE;
        endcase
    end

    // Each of AW and W is forwarded once; after its handshake the channel is masked off.
    always_comb begin
        w_state_nxt = w_state;
        wgnt_nxt    = wgnt;
        aw_done_nxt = aw_done;
        w_done_nxt  = w_done;
        m_awvalid_c = 1'b0;
        m_wvalid_c  = 1'b0;
        m_bready_c  = 1'b0;
        s_awready   = 2'b00;
        s_wready    = 2'b00;
        s_bvalid    = 2'b00;
        b_done      = 1'b0;
        case (w_state)
            W_IDLE: begin
                if (s0.awvalid || s1.awvalid) begin
                    wgnt_nxt    = w_win;
                    w_state_nxt = W_XFER;
                end
            end
            W_XFER: begin
                m_awvalid_c     = (wgnt ? s1.awvalid : s0.awvalid) & ~aw_done;
                m_wvalid_c      = (wgnt ? s1.wvalid : s0.wvalid) & ~w_done;
                s_awready[wgnt] = m.awready & ~aw_done;
                s_wready[wgnt]  = m.wready & ~w_done;
                aw_done_nxt     = aw_done | (m_awvalid_c & m.awready);
                w_done_nxt      = w_done | (m_wvalid_c & m.wready);
                if (aw_done_nxt && w_done_nxt) begin
                    aw_done_nxt = 1'b0;
                    w_done_nxt  = 1'b0;
                    w_state_nxt = W_RESP;
                end
            end
            W_RESP: begin
                m_bready_c     = wgnt ? s1.bready : s0.bready;
                s_bvalid[wgnt] = m.bvalid;
                if (m.bvalid && m_bready_c) begin
                    b_done      = 1'b1;
                    w_state_nxt = W_IDLE;
                end
            end
            default: w_state_nxt = W_IDLE;
        endcase
    end

    assign m.araddr  = rgnt ? s1.araddr  : s0.araddr;
    assign m.arburst = rgnt ? s1.arburst : s0.arburst;
    assign m.arsize  = rgnt ? s1.arsize  : s0.arsize;
    assign m.arid    = rgnt ? s1.arid    : s0.arid;
    assign m.arlen   = rgnt ? s1.arlen   : s0.arlen;
    assign m.arvalid = m_arvalid_c;
    assign m.rready  = m_rready_c;

    assign m.awaddr  = wgnt ? s1.awaddr  : s0.awaddr;
    assign m.awburst = wgnt ? s1.awburst : s0.awburst;
    assign m.awsize  = wgnt ? s1.awsize  : s0.awsize;
    assign m.awid    = wgnt ? s1.awid    : s0.awid;
    assign m.awlen   = wgnt ? s1.awlen   : s0.awlen;
    assign m.awvalid = m_awvalid_c;
    assign m.wdata   = wgnt ? s1.wdata   : s0.wdata;
    assign m.wstrb   = wgnt ? s1.wstrb   : s0.wstrb;
    assign m.wid     = wgnt ? s1.wid     : s0.wid;
    assign m.wlast   = wgnt ? s1.wlast   : s0.wlast;
    assign m.wvalid  = m_wvalid_c;
    assign m.bready  = m_bready_c;

    assign s0.arready = s_arready[0];
    assign s0.rdata   = m.rdata;
    assign s0.rresp   = m.rresp;
    assign s0.rid     = m.rid;
    assign s0.rlast   = m.rlast;
    assign s0.rvalid  = s_rvalid[0];
    assign s0.awready = s_awready[0];
    assign s0.wready  = s_wready[0];
    assign s0.bid     = m.bid;
    assign s0.bresp   = m.bresp;
    assign s0.bvalid  = s_bvalid[0];

    assign s1.arready = s_arready[1];
    assign s1.rdata   = m.rdata;
    assign s1.rresp   = m.rresp;
    assign s1.rid     = m.rid;
    assign s1.rlast   = m.rlast;
    assign s1.rvalid  = s_rvalid[1];
    assign s1.awready = s_awready[1];
    assign s1.wready  = s_wready[1];
    assign s1.bid     = m.bid;
    assign s1.bresp   = m.bresp;
    assign s1.bvalid  = s_bvalid[1];
endmodule

// File: tb/tb_l1_axi_arb.sv
// Directed bench for l1_axi_arb: the bench plays both L1 masters and the interconnect slave.
module tb_l1_axi_arb;
    localparam int RS_IDLE = 0, RS_ADDR = 1, RS_DATA = 2;
    localparam int WS_IDLE = 0, WS_XFER = 1, WS_RESP = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vec_cnt = 0;
    int   err_cnt = 0;
    int   aw_hs_cnt = 0;
    int   w_hs_cnt = 0;

    l1_axi_arb_if #(.AW(32), .DW(32), .IDW(10)) s0_if ();
    l1_axi_arb_if #(.AW(32), .DW(32), .IDW(10)) s1_if ();
    l1_axi_arb_if #(.AW(32), .DW(32), .IDW(10)) m_if ();

    l1_axi_arb dut (
        .clk (clk),
        .rst (rst),
        .s0  (s0_if),
        .s1  (s1_if),
        .m   (m_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (m_if.awvalid && m_if.awready) aw_hs_cnt <= aw_hs_cnt + 1;
        if (m_if.wvalid && m_if.wready)   w_hs_cnt  <= w_hs_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [14:0] hs_vec();
        return {s0_if.arready, s1_if.arready, s0_if.rvalid, s1_if.rvalid,
                s0_if.awready, s1_if.awready, s0_if.wready, s1_if.wready,
                s0_if.bvalid, s1_if.bvalid, m_if.arvalid, m_if.awvalid,
                m_if.wvalid, m_if.rready, m_if.bready};
    endfunction

    task automatic set_ar(input bit who, input logic v, input logic [31:0] addr,
                          input logic [7:0] len, input logic [9:0] id);
        if (who) begin
            s1_if.arvalid = v; s1_if.araddr = addr; s1_if.arlen = len; s1_if.arid = id;
        end else begin
            s0_if.arvalid = v; s0_if.araddr = addr; s0_if.arlen = len; s0_if.arid = id;
        end
    endtask

    task automatic set_wr(input bit who, input logic v, input logic [31:0] addr,
                          input logic [31:0] data, input logic [9:0] id);
        if (who) begin
            s1_if.awvalid = v; s1_if.wvalid = v; s1_if.awaddr = addr;
            s1_if.wdata = data; s1_if.awid = id; s1_if.wid = id;
        end else begin
            s0_if.awvalid = v; s0_if.wvalid = v; s0_if.awaddr = addr;
            s0_if.wdata = data; s0_if.awid = id; s0_if.wid = id;
        end
    endtask

    // Called in R_ADDR with s[who] requesting: checks AR pass-through and completes the handshake.
    task automatic rd_addr(input bit who, input logic [31:0] addr, input logic [7:0] len,
                           input logic [9:0] id);
        chk("r_state_addr", 64'(dut.r_state), RS_ADDR);
        chk("m_arvalid", m_if.arvalid, 1);
        chk("m_araddr", m_if.araddr, addr);
        chk("m_arlen", m_if.arlen, len);
        chk("m_arid", m_if.arid, id);
        m_if.arready = 1'b1;
        #1;
        chk("ar_ready_gnt", who ? s1_if.arready : s0_if.arready, 1);
        chk("ar_ready_other", who ? s0_if.arready : s1_if.arready, 0);
        tick();
        m_if.arready = 1'b0;
    endtask

    task automatic rd_beats(input bit who, input logic [7:0] len, input logic [31:0] dbase);
        if (who) s1_if.rready = 1'b1; else s0_if.rready = 1'b1;
        for (int i = 0; i <= int'(len); i++) begin
            m_if.rvalid = 1'b1;
            m_if.rdata  = dbase + 32'(i);
            m_if.rlast  = (i == int'(len));
            #1;
            chk("r_data", who ? s1_if.rdata : s0_if.rdata, dbase + 32'(i));
            chk("r_valid_gnt", who ? s1_if.rvalid : s0_if.rvalid, 1);
            chk("r_last", who ? s1_if.rlast : s0_if.rlast, (i == int'(len)));
            chk("r_valid_other", who ? s0_if.rvalid : s1_if.rvalid, 0);
            chk("m_rready", m_if.rready, 1);
            tick();
        end
        m_if.rvalid = 1'b0;
        m_if.rlast  = 1'b0;
        s0_if.rready = 1'b0;
        s1_if.rready = 1'b0;
        chk("r_idle_after_last", 64'(dut.r_state), RS_IDLE);
    endtask

    task automatic wr_resp(input bit who, input logic [1:0] resp, input logic [9:0] id);
        chk("w_state_resp", 64'(dut.w_state), WS_RESP);
        m_if.bvalid = 1'b1;
        m_if.bresp  = resp;
        m_if.bid    = id;
        if (who) s1_if.bready = 1'b1; else s0_if.bready = 1'b1;
        #1;
        chk("b_valid_gnt", who ? s1_if.bvalid : s0_if.bvalid, 1);
        chk("b_valid_other", who ? s0_if.bvalid : s1_if.bvalid, 0);
        chk("b_resp", who ? s1_if.bresp : s0_if.bresp, resp);
        chk("b_id", who ? s1_if.bid : s0_if.bid, id);
        chk("m_bready", m_if.bready, 1);
        tick();
        m_if.bvalid = 1'b0;
        s0_if.bready = 1'b0;
        s1_if.bready = 1'b0;
        chk("w_idle_after_b", 64'(dut.w_state), WS_IDLE);
    endtask

    initial begin
        bit g2;
        int aw0, w0;

        set_ar(0, 0, 0, 0, 0);
        set_ar(1, 0, 0, 0, 0);
        set_wr(0, 0, 0, 0, 0);
        set_wr(1, 0, 0, 0, 0);
        s0_if.arburst = 2'd1; s0_if.arsize = 3'd2; s1_if.arburst = 2'd1; s1_if.arsize = 3'd2;
        s0_if.awburst = 2'd1; s0_if.awsize = 3'd2; s1_if.awburst = 2'd1; s1_if.awsize = 3'd2;
        s0_if.awlen = 8'd0; s1_if.awlen = 8'd0; s0_if.wlast = 1'b1; s1_if.wlast = 1'b1;
        s0_if.wstrb = 4'hF; s1_if.wstrb = 4'hF;
        s0_if.rready = 0; s1_if.rready = 0; s0_if.bready = 0; s1_if.bready = 0;
        m_if.arready = 0; m_if.awready = 0; m_if.wready = 0;
        m_if.rvalid = 0; m_if.rlast = 0; m_if.rdata = 0; m_if.rresp = 0; m_if.rid = 0;
        m_if.bvalid = 0; m_if.bresp = 0; m_if.bid = 0;

        tick();
        tick();
        rst = 1'b0;
        chk("reset_hs_zero", 64'(hs_vec()), 0);
        chk("reset_r_idle", 64'(dut.r_state), RS_IDLE);
        chk("reset_w_idle", 64'(dut.w_state), WS_IDLE);

        // Reset in the middle of a read burst
        set_ar(0, 1, 32'h0000_0800, 8'd3, 10'h001);
        #1;
        chk("ridle_no_arready", s0_if.arready, 0);
        chk("ridle_no_m_arvalid", m_if.arvalid, 0);
        tick();
        rd_addr(0, 32'h0000_0800, 8'd3, 10'h001);
        set_ar(0, 0, 0, 0, 0);
        s0_if.rready = 1'b1;
        m_if.rvalid = 1'b1; m_if.rdata = 32'h55; m_if.rlast = 1'b0;
        tick();
        chk("mid_burst_r_data", 64'(dut.r_state), RS_DATA);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("midrst_hs_zero", 64'(hs_vec()), 0);
        chk("midrst_r_idle", 64'(dut.r_state), RS_IDLE);
        m_if.rvalid = 1'b0;
        s0_if.rready = 1'b0;

        // s0 alone, four beats
        set_ar(0, 1, 32'h0000_1000, 8'd3, 10'h002);
        tick();
        rd_addr(0, 32'h0000_1000, 8'd3, 10'h002);
        set_ar(0, 0, 0, 0, 0);
        rd_beats(0, 8'd3, 32'hA0);

        // Tie on AR: s1 first, then s0 under round-robin, s1 again under fixed priority
        set_ar(0, 1, 32'h0000_1100, 8'd0, 10'h010);
        set_ar(1, 1, 32'h0000_3100, 8'd0, 10'h011);
        tick();
        rd_addr(1, 32'h0000_3100, 8'd0, 10'h011);
        rd_beats(1, 8'd0, 32'hB0);
        tick();
`ifdef L1_ARB_RR_EN
        g2 = 1'b0;
`else
        g2 = 1'b1;
`endif
        if (g2) set_ar(0, 0, 0, 0, 0); else set_ar(1, 0, 0, 0, 0);
        #1;
        rd_addr(g2, g2 ? 32'h0000_3100 : 32'h0000_1100, 8'd0, g2 ? 10'h011 : 10'h010);
        set_ar(g2, 0, 0, 0, 0);
        rd_beats(g2, 8'd0, 32'hB8);

        // s1 write, AW and W accepted in the same cycle
        set_wr(1, 1, 32'h0000_2004, 32'hDEAD_BEEF, 10'h003);
        #1;
        chk("widle_no_wready", s1_if.wready, 0);
        chk("widle_no_m_awvalid", m_if.awvalid, 0);
        tick();
        chk("w_state_xfer", 64'(dut.w_state), WS_XFER);
        chk("m_awaddr", m_if.awaddr, 32'h0000_2004);
        chk("m_wdata", m_if.wdata, 32'hDEAD_BEEF);
        chk("m_wstrb", m_if.wstrb, 4'hF);
        m_if.awready = 1'b1; m_if.wready = 1'b1;
        #1;
        chk("w1_awready", s1_if.awready, 1);
        chk("w1_wready", s1_if.wready, 1);
        chk("w1_other_ready", {s0_if.awready, s0_if.wready}, 0);
        tick();
        m_if.awready = 1'b0; m_if.wready = 1'b0;
        set_wr(1, 0, 0, 0, 0);
        wr_resp(1, 2'b10, 10'h003);

        // s1 write, AW accepted two cycles after W
        aw0 = aw_hs_cnt;
        w0  = w_hs_cnt;
        set_wr(1, 1, 32'h0000_2004, 32'hDEAD_BEEF, 10'h004);
        tick();
        m_if.wready = 1'b1;
        #1;
        chk("w2_m_wvalid", m_if.wvalid, 1);
        chk("w2_awready_low", s1_if.awready, 0);
        tick();
        chk("w2_still_xfer", 64'(dut.w_state), WS_XFER);
        chk("w2_wvalid_masked", m_if.wvalid, 0);
        chk("w2_wready_masked", s1_if.wready, 0);
        tick();
        m_if.awready = 1'b1;
        #1;
        chk("w2_m_awvalid", m_if.awvalid, 1);
        chk("w2_awready", s1_if.awready, 1);
        tick();
        m_if.awready = 1'b0; m_if.wready = 1'b0;
        set_wr(1, 0, 0, 0, 0);
        chk("w2_aw_hs_count", 64'(aw_hs_cnt - aw0), 1);
        chk("w2_w_hs_count", 64'(w_hs_cnt - w0), 1);
        wr_resp(1, 2'b00, 10'h004);

        // Concurrent s0 read and s1 write
        set_ar(0, 1, 32'h0000_1200, 8'd3, 10'h005);
        set_wr(1, 1, 32'h0000_2008, 32'h1234_5678, 10'h006);
        tick();
        chk("cc_r_addr", 64'(dut.r_state), RS_ADDR);
        chk("cc_w_xfer", 64'(dut.w_state), WS_XFER);
        m_if.arready = 1'b1; m_if.awready = 1'b1; m_if.wready = 1'b1;
        #1;
        chk("cc_s0_arready", s0_if.arready, 1);
        chk("cc_s1_awready", s1_if.awready, 1);
        tick();
        m_if.arready = 1'b0; m_if.awready = 1'b0; m_if.wready = 1'b0;
        set_ar(0, 0, 0, 0, 0);
        set_wr(1, 0, 0, 0, 0);
        chk("cc_r_data", 64'(dut.r_state), RS_DATA);
        wr_resp(1, 2'b00, 10'h006);
        chk("cc_r_still_data", 64'(dut.r_state), RS_DATA);
        rd_beats(0, 8'd3, 32'hC0);

        // Back-to-back reads with arvalid held
        for (int k = 0; k < 3; k++) begin
            set_ar(0, 1, 32'h0000_4000 + 32'(k * 16), 8'd1, 10'h020);
            #1;
            chk("b2b_idle_gap", 64'(dut.r_state), RS_IDLE);
            tick();
            rd_addr(0, 32'h0000_4000 + 32'(k * 16), 8'd1, 10'h020);
            if (k == 2) set_ar(0, 0, 0, 0, 0);
            rd_beats(0, 8'd1, 32'h0000_0100 * 32'(k + 1));
        end
        tick();
        chk("end_r_idle", 64'(dut.r_state), RS_IDLE);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule

// File: doc/l1_axi_arb.md
Name: l1_axi_arb

Overview:
- Two-master to one-master AXI arbiter directly downstream of the L1 caches.
- s0 is the L1 instruction cache and s1 the L1 data cache; both are cache-controller AXI masters.
- m is the single port to the system interconnect.
- Read (AR/R) and write (AW/W/B) channels are arbitrated independently.
- Each channel is locked to its granted master for one whole transaction: one outstanding read plus one outstanding write, system-wide.

Parameters:
- AW, 32, address width.
- DW, 32, data width; strobe width is DW/8.
- IDW, 10, AXI ID width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high. One clock; reset is synchronous and active-high.
- sN_araddr/arburst/arsize/arid/arlen/arvalid  in  AW/2/3/IDW/8/1  read address from master N (N=0,1).
- sN_arready  out  1  read address ready to master N.
- sN_rdata/rresp/rid/rlast/rvalid  out  DW/2/IDW/1/1  read data to master N.
- sN_rready  in  1  read data ready from master N.
- sN_awaddr/awburst/awsize/awid/awlen/awvalid  in  AW/2/3/IDW/8/1  write address from master N.
- sN_awready  out  1  write address ready to master N.
- sN_wdata/wstrb/wid/wlast/wvalid  in  DW/DW/8/IDW/1/1  write data from master N.
- sN_wready  out  1  write data ready to master N.
- sN_bid/bresp/bvalid  out  IDW/2/1  write response to master N.
- sN_bready  in  1  write response ready from master N.
- m_*  mirror set of all the above, opposite direction, toward the interconnect.

Behaviour:
- Reset (rst=1 at a clk edge):
  - both FSMs go to IDLE, both grant registers go to 0, the round-robin pointer goes to 0.
  - All sN_*ready, sN_rvalid, sN_bvalid, m_arvalid, m_awvalid, m_wvalid read 0.
  - m_rready and m_bready read 0.
  - Reset mid-burst abandons the transaction with no drain.
- Read FSM states R_IDLE, R_ADDR, R_DATA:
  - R_IDLE: if any sN_arvalid, register rgnt = winner and go to R_ADDR. Grant costs 1 cycle. No ready is asserted in R_IDLE.
  - R_ADDR: AR payload, m_arvalid and s[rgnt]_arready pass through combinationally from the selected master. Go to R_DATA on m_arvalid & m_arready.
  - R_DATA: R payload routes to s[rgnt]; m_rready = s[rgnt]_rready. The other master sees rvalid=0. Go to R_IDLE on m_rvalid & m_rready & m_rlast.
- Write FSM states W_IDLE, W_XFER, W_RESP:
  - W_IDLE: if any sN_awvalid, register wgnt and go to W_XFER.
  - W_XFER: AW and W of s[wgnt] pass through. Sticky flags aw_done and w_done set on their respective handshakes.
  - After a handshake its channel's valid and ready are masked to 0 until the FSM leaves W_XFER.
  - W_XFER ends when both handshakes complete, or when the last one completes in the current cycle; both may complete in the same cycle. Flags then clear and the FSM goes to W_RESP.
  - Only single-beat writes (awlen=0, wlast=1) are supported. Multi-beat writes are unsupported; behaviour is undefined.
  - W_RESP: B routes to s[wgnt]; m_bready = s[wgnt]_bready. Go to W_IDLE on m_bvalid & m_bready.
- sN_wvalid before sN_awvalid from a master in W_IDLE is held off (wready=0) until that master is granted.
- Priority (macro absent): fixed, s1 (D-cache) wins when both request in the same cycle.
- Non-granted masters always see ready=0 and valid=0 on every channel.
- All IDs, resp, burst, size and len pass through unchanged; there is no ID remap.
- Read and write FSMs are fully concurrent, e.g. s0 read while s1 write.
- Back-to-back: after returning to IDLE, a still-asserted request is re-arbitrated. The minimum gap is 1 idle cycle between transactions.

Optional Feature:
- L1_ARB_RR_EN defined: round-robin per channel.
  - A 1-bit pointer per channel; on a tie the winner is the master not granted last on that channel.
  - The pointer updates when the transaction completes (R_DATA or W_RESP exit).
- Undefined: fixed priority s1 > s0, and no pointer flops.

Test Plan:
- Reset mid-R_DATA: rst=1 for 1 cycle -> next cycle all valids and readys are 0 and the FSM is in R_IDLE; a fresh s0 read then completes normally.
- s0 alone, araddr=0x0000_1000, arlen=3 -> m_araddr=0x0000_1000 in R_ADDR; 4 beats 0xA0..0xA3 reach s0_rdata with rlast on beat 4; s1_rvalid stays 0 throughout.
- s0 and s1 assert arvalid in the same cycle -> s1 granted first. With L1_ARB_RR_EN, the next tie after s1 completes grants s0.
- s1 write awaddr=0x0000_2004, wdata=0xDEADBEEF, wstrb=0xF:
  - case 1, m_awready=1 and m_wready=1 in the same cycle -> W_RESP after exactly 1 W_XFER cycle.
  - case 2, m_awready 2 cycles late -> single AW handshake and single W handshake; bresp=0 returned only to s1.
- Concurrency: s0 read (arlen=3) and s1 write issued together -> both complete, with W_RESP entered while R_DATA is still in progress.
- Back-to-back: s0 holds arvalid across 3 reads -> each new R_ADDR follows exactly 1 R_IDLE cycle after the previous rlast handshake.
